// File: rtl/icache_line_fetcher.sv
// Fetch-line buffer producer: holds the current I$ line and issues single-outstanding refills.
// Optional performance counters are enabled with `define ICACHE_LF_PERF_EN.
module icache_line_fetcher #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned LINE_OFFSET = 4,
    parameter int unsigned LINE_W      = 128
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              pc_valid_i,
    input  logic              flush_i,
    output logic [XLEN-1:0]   line_pc_o,
    output logic              line_valid_o,
    output logic [LINE_W-1:0] line_o,
    output logic [XLEN-1:0]   pend_pc_o,
    output logic              pend_valid_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [XLEN-1:0]   req_addr_o,
    input  logic              resp_valid_i,
    input  logic [LINE_W-1:0] resp_line_i
`ifdef ICACHE_LF_PERF_EN
    ,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       flush_kill_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;
    logic   kill_q, kill_d;

    logic              hit;
    logic              pend_hit;
    logic              miss;
    logic [XLEN-1:0]   pc_aligned;
    logic              unused_pc_lsb;

    logic [XLEN-1:0]   line_pc_d;
    logic              line_valid_d;
    logic [LINE_W-1:0] line_d;
    logic [XLEN-1:0]   pend_pc_d;
    logic              pend_valid_d;
    logic              req_valid_d;
    logic [XLEN-1:0]   req_addr_d;

    assign pc_aligned    = {pc_i[XLEN-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
    assign unused_pc_lsb = ^pc_i[LINE_OFFSET-1:0];

    assign hit      = line_valid_o & (pc_i[XLEN-1:LINE_OFFSET] == line_pc_o[XLEN-1:LINE_OFFSET]);
    assign pend_hit = pend_valid_o & (pc_i[XLEN-1:LINE_OFFSET] == pend_pc_o[XLEN-1:LINE_OFFSET]);
    assign miss     = pc_valid_i & ~hit & ~pend_hit & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // A flush during REQ cannot retract the request, so it is remembered in
    // kill and applied when the handshake completes.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (req_ready_i) begin
                    state_d = (kill_q | flush_i) ? S_DRAIN : S_WAIT;
                    kill_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = resp_valid_i ? S_IDLE : S_DRAIN;
                end else if (resp_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (resp_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        line_pc_d    = line_pc_o;
        line_valid_d = line_valid_o;
        line_d       = line_o;
        pend_pc_d    = pend_pc_o;
        pend_valid_d = pend_valid_o;
        req_valid_d  = req_valid_o;
        req_addr_d   = req_addr_o;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    req_valid_d  = 1'b1;
                    req_addr_d   = pc_aligned;
                    pend_pc_d    = pc_aligned;
                    pend_valid_d = 1'b1;
                end
            end
            S_REQ: begin
                if (req_ready_i) begin
                    req_valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (resp_valid_i && !flush_i) begin
                    line_d       = resp_line_i;
                    line_pc_d    = pend_pc_o;
                    line_valid_d = 1'b1;
                    pend_valid_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
        // Request signals are deliberately left untouched so the handshake stays legal.
        if (flush_i) begin
            line_valid_d = 1'b0;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_pc_o    <= '0;
            line_valid_o <= 1'b0;
            line_o       <= '0;
            pend_pc_o    <= '0;
            pend_valid_o <= 1'b0;
            req_valid_o  <= 1'b0;
            req_addr_o   <= '0;
        end else begin
            line_pc_o    <= line_pc_d;
            line_valid_o <= line_valid_d;
            line_o       <= line_d;
            pend_pc_o    <= pend_pc_d;
            pend_valid_o <= pend_valid_d;
            req_valid_o  <= req_valid_d;
            req_addr_o   <= req_addr_d;
        end
    end

`ifdef ICACHE_LF_PERF_EN
    logic miss_inc;
    logic kill_inc;

    assign miss_inc = (state_q == S_IDLE) && (state_d == S_REQ);
    assign kill_inc = (state_q != S_DRAIN) && (state_d == S_DRAIN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            miss_cnt_o       <= '0;
            flush_kill_cnt_o <= '0;
        end else begin
            if (miss_inc && (miss_cnt_o != '1)) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
            if (kill_inc && (flush_kill_cnt_o != '1)) begin
                flush_kill_cnt_o <= flush_kill_cnt_o + 32'd1;
            end
        end
    end
`endif

    // Responses are only legal while a request is in flight; stray ones are dropped.
    resp_outside_wait: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        resp_valid_i |-> (state_q == S_WAIT || state_q == S_DRAIN))
        else $warning("resp_valid_i outside WAIT/DRAIN ignored");

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Directed plus randomized bench for icache_line_fetcher against a line-level reference model.
// Also checks the counters when ICACHE_LF_PERF_EN is defined.
module tb_icache_line_fetcher;

    localparam logic [31:0] MASK = 32'hFFFF_FFF0;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [31:0]  pc_i;
    logic         pc_valid_i;
    logic         flush_i;
    logic [31:0]  line_pc_o;
    logic         line_valid_o;
    logic [127:0] line_o;
    logic [31:0]  pend_pc_o;
    logic         pend_valid_o;
    logic         req_valid_o;
    logic         req_ready_i;
    logic [31:0]  req_addr_o;
    logic         resp_valid_i;
    logic [127:0] resp_line_i;
`ifdef ICACHE_LF_PERF_EN
    logic [31:0]  miss_cnt_o;
    logic [31:0]  flush_kill_cnt_o;
`endif

    icache_line_fetcher #(
        .XLEN        (32),
        .LINE_OFFSET (4),
        .LINE_W      (128)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .flush_i      (flush_i),
        .line_pc_o    (line_pc_o),
        .line_valid_o (line_valid_o),
        .line_o       (line_o),
        .pend_pc_o    (pend_pc_o),
        .pend_valid_o (pend_valid_o),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_addr_o   (req_addr_o),
        .resp_valid_i (resp_valid_i),
        .resp_line_i  (resp_line_i)
`ifdef ICACHE_LF_PERF_EN
        ,
        .miss_cnt_o       (miss_cnt_o),
        .flush_kill_cnt_o (flush_kill_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: what the line buffer should hold, plus expected event counts.
    logic         mdl_valid;
    logic [31:0]  mdl_pc;
    logic [127:0] mdl_data;
    int unsigned  exp_miss;
    int unsigned  exp_kill;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".line_valid"}, line_valid_o, 0);
        chk({tag, ".line_pc"}, line_pc_o, 0);
        chk({tag, ".line"}, line_o, 0);
        chk({tag, ".pend_valid"}, pend_valid_o, 0);
        chk({tag, ".pend_pc"}, pend_pc_o, 0);
        chk({tag, ".req_valid"}, req_valid_o, 0);
        chk({tag, ".req_addr"}, req_addr_o, 0);
    endtask

    // Full miss transaction: request, optional backpressure, response, line install.
    task automatic do_fetch(input logic [31:0] pc, input int unsigned rdy_dly,
                            input int unsigned rsp_dly, input logic [127:0] data);
        logic [31:0] a;
        a = pc & MASK;
        pc_i       = pc;
        pc_valid_i = 1'b1;
        tick();
        chk("fetch.req_valid", req_valid_o, 1);
        chk("fetch.req_addr", req_addr_o, a);
        chk("fetch.pend", {pend_valid_o, pend_pc_o}, {1'b1, a});
        for (int unsigned i = 0; i < rdy_dly; i++) begin
            tick();
            chk("fetch.bp_valid", req_valid_o, 1);
            chk("fetch.bp_addr", req_addr_o, a);
        end
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        chk("fetch.req_drop", req_valid_o, 0);
        for (int unsigned i = 0; i < rsp_dly; i++) begin
            tick();
            chk("fetch.wait_pend", pend_valid_o, 1);
        end
        resp_valid_i = 1'b1;
        resp_line_i  = data;
        tick();
        resp_valid_i = 1'b0;
        chk("fetch.line_valid", line_valid_o, 1);
        chk("fetch.line_pc", line_pc_o, a);
        chk("fetch.line", line_o, data);
        chk("fetch.pend_clear", pend_valid_o, 0);
        mdl_valid = 1'b1;
        mdl_pc    = a;
        mdl_data  = data;
        exp_miss++;
    endtask

    // Miss accepted, then flushed while waiting; the late response must be discarded.
    task automatic do_flush_wait(input logic [31:0] pc, input int unsigned rsp_dly,
                                 input logic [127:0] data);
        logic [31:0] a;
        a = pc & MASK;
        pc_i       = pc;
        pc_valid_i = 1'b1;
        tick();
        chk("fw.req_valid", req_valid_o, 1);
        chk("fw.req_addr", req_addr_o, a);
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        chk("fw.req_drop", req_valid_o, 0);
        flush_i    = 1'b1;
        pc_valid_i = 1'b0;
        tick();
        flush_i = 1'b0;
        chk("fw.line_valid", line_valid_o, 0);
        chk("fw.pend_valid", pend_valid_o, 0);
        for (int unsigned i = 0; i < rsp_dly; i++) tick();
        resp_valid_i = 1'b1;
        resp_line_i  = data;
        tick();
        resp_valid_i = 1'b0;
        chk("fw.discard_valid", line_valid_o, 0);
        chk("fw.discard_pc", line_pc_o, mdl_pc);
        chk("fw.discard_line", line_o, mdl_data);
        mdl_valid = 1'b0;
        exp_miss++;
        exp_kill++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0]  pc;
        logic [127:0] data;
        int unsigned  sel;

        rst_n_i      = 1'b0;
        pc_i         = '0;
        pc_valid_i   = 1'b0;
        flush_i      = 1'b0;
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_line_i  = '0;
        mdl_valid    = 1'b0;
        mdl_pc       = '0;
        mdl_data     = '0;
        exp_miss     = 0;
        exp_kill     = 0;
        #12;
        chk_zero_outputs("reset");
        rst_n_i = 1'b1;
        tick();
        chk_zero_outputs("post_reset");

        // Cold miss.
        do_fetch(32'h0000_1004, 1, 2, 128'hDEADBEEF_00112233_44556677_DEADBEEF);

        // Hit inside the buffered line.
        pc_i = 32'h0000_100C;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hit.no_req", req_valid_o, 0);
            chk("hit.line_pc", line_pc_o, 32'h0000_1000);
        end

        // Pending hit: same line as the in-flight request must not re-request.
        pc_i = 32'h0000_2000;
        tick();
        chk("pend.req_addr", req_addr_o, 32'h0000_2000);
        pc_i        = 32'h0000_2008;
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("pend.no_req", req_valid_o, 0);
            chk("pend.pend_pc", {pend_valid_o, pend_pc_o}, {1'b1, 32'h0000_2000});
        end
        resp_valid_i = 1'b1;
        resp_line_i  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        tick();
        resp_valid_i = 1'b0;
        chk("pend.line_pc", line_pc_o, 32'h0000_2000);
        tick();
        chk("pend.after_hit", req_valid_o, 0);
        mdl_valid = 1'b1;
        mdl_pc    = 32'h0000_2000;
        mdl_data  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

        // Backpressure for 5 cycles.
        do_fetch(32'h0000_3004, 5, 1, {$urandom, $urandom, $urandom, $urandom});

        // Flush in WAIT, response three cycles later, then a normal miss.
        do_flush_wait(32'h0000_4000, 2, {$urandom, $urandom, $urandom, $urandom});
        do_fetch(32'h0000_5000, 0, 1, {$urandom, $urandom, $urandom, $urandom});

        // Flush in REQ: request stays up until accepted, then response is drained.
        pc_i       = 32'h0000_6000;
        pc_valid_i = 1'b1;
        tick();
        chk("freq.req_valid", req_valid_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i    = 1'b0;
        pc_valid_i = 1'b0;
        chk("freq.held_valid", req_valid_o, 1);
        chk("freq.held_addr", req_addr_o, 32'h0000_6000);
        chk("freq.pend_valid", pend_valid_o, 0);
        chk("freq.line_valid", line_valid_o, 0);
        tick();
        chk("freq.still_held", req_valid_o, 1);
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        chk("freq.req_drop", req_valid_o, 0);
        tick();
        resp_valid_i = 1'b1;
        resp_line_i  = {4{32'hBAD0_BAD0}};
        tick();
        resp_valid_i = 1'b0;
        chk("freq.discard_valid", line_valid_o, 0);
        chk("freq.discard_pc", line_pc_o, mdl_pc);
        chk("freq.discard_line", line_o, mdl_data);
        mdl_valid = 1'b0;
        exp_miss++;
        exp_kill++;
        do_fetch(32'h0000_6000, 0, 0, {$urandom, $urandom, $urandom, $urandom});

        // Flush and response in the same WAIT cycle: flush wins.
        pc_i       = 32'h0000_7000;
        pc_valid_i = 1'b1;
        tick();
        chk("fr.req_valid", req_valid_o, 1);
        req_ready_i = 1'b1;
        tick();
        req_ready_i  = 1'b0;
        flush_i      = 1'b1;
        resp_valid_i = 1'b1;
        resp_line_i  = {4{32'hFEED_FACE}};
        pc_valid_i   = 1'b0;
        tick();
        flush_i      = 1'b0;
        resp_valid_i = 1'b0;
        chk("fr.line_valid", line_valid_o, 0);
        chk("fr.line_pc", line_pc_o, mdl_pc);
        chk("fr.line", line_o, mdl_data);
        chk("fr.pend_valid", pend_valid_o, 0);
        mdl_valid = 1'b0;
        exp_miss++;
        do_fetch(32'h0000_7000, 0, 0, {$urandom, $urandom, $urandom, $urandom});

        // Asynchronous reset while waiting for a response.
        pc_i       = 32'h0000_8000;
        pc_valid_i = 1'b1;
        tick();
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
`ifdef ICACHE_LF_PERF_EN
        chk("async_rst.miss_cnt", miss_cnt_o, 0);
        chk("async_rst.kill_cnt", flush_kill_cnt_o, 0);
`endif
        #2;
        rst_n_i    = 1'b1;
        pc_valid_i = 1'b0;
        tick();
        resp_valid_i = 1'b1;
        resp_line_i  = {4{32'h1A7E_1A7E}};
        tick();
        resp_valid_i = 1'b0;
        tick();
        chk_zero_outputs("late_resp");
        mdl_valid = 1'b0;
        mdl_pc    = '0;
        mdl_data  = '0;
        exp_miss  = 0;
        exp_kill  = 0;

        // Randomized traffic against the line model.
        for (int i = 0; i < 40; i++) begin
            sel  = $urandom_range(0, 3);
            if (mdl_valid && sel == 0) begin
                pc = {mdl_pc[31:4], 4'($urandom)};
            end else begin
                pc = $urandom & 32'h0003_FFFF;
            end
            data = {$urandom, $urandom, $urandom, $urandom};
            if (mdl_valid && (pc[31:4] == mdl_pc[31:4])) begin
                pc_i       = pc;
                pc_valid_i = 1'b1;
                tick();
                chk("rnd.hit_no_req", req_valid_o, 0);
                chk("rnd.hit_line", {line_valid_o, line_pc_o, line_o}, {1'b1, mdl_pc, mdl_data});
            end else if (sel == 1) begin
                do_flush_wait(pc, $urandom_range(0, 3), data);
            end else begin
                do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 4), data);
            end
        end

`ifdef ICACHE_LF_PERF_EN
        chk("perf.miss_cnt", miss_cnt_o, exp_miss);
        chk("perf.kill_cnt", flush_kill_cnt_o, exp_kill);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_line_fetcher.md
Name: icache_line_fetcher

Overview:
- Producer of the fetch-line buffer: holds the current instruction-cache line plus its line-aligned PC and valid bit.
- Issues line refill requests to the instruction cache on a miss, with at most one request outstanding.
- Exposes the address of the in-flight request so fetch-stage presence logic can tell "here now" from "arriving soon".
- Sits between the fetch-stage PC/presence logic and the I$ request/response port.

Parameters:
- XLEN, 32, PC and address width.
- LINE_OFFSET, 4, log2 of line size in bytes (ICACHE_OFFSET+OFFSET); line tag = pc[XLEN-1:LINE_OFFSET].
- LINE_W, 128, line data width in bits; must equal 8*2^LINE_OFFSET.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- pc_i  in  XLEN  PC the fetch stage wants.
- pc_valid_i  in  1  pc_i is meaningful this cycle.
- flush_i  in  1  invalidate line buffer; kill any in-flight request.
- line_pc_o  out  XLEN  line-aligned PC of buffered line (low LINE_OFFSET bits 0).
- line_valid_o  out  1  line buffer holds valid data.
- line_o  out  LINE_W  buffered line data.
- pend_pc_o  out  XLEN  line-aligned PC of outstanding, non-killed request.
- pend_valid_o  out  1  pend_pc_o valid.
- req_valid_o  out  1  refill request valid.
- req_ready_i  in  1  cache accepts request.
- req_addr_o  out  XLEN  line-aligned request address.
- resp_valid_i  in  1  refill data valid (single beat).
- resp_line_i  in  LINE_W  refill data.

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; line_valid_o=0, line_pc_o=0, line_o=0, pend_valid_o=0, pend_pc_o=0, req_valid_o=0, req_addr_o=0. All state registers are async-reset; outputs come directly from registers.
- hit = line_valid_o & (pc_i tag == line_pc_o tag).
- pend_hit = pend_valid_o & (pc_i tag == pend_pc_o tag).
- miss = pc_valid_i & !hit & !pend_hit & !flush_i.
- State IDLE:
  - On miss: latch req_addr_o = pend_pc_o = {pc_i tag, LINE_OFFSET zeros}.
  - Next cycle: req_valid_o=1, pend_valid_o=1; go REQ.
  - Miss-to-request latency is 1 cycle.
- State REQ:
  - req_valid_o and req_addr_o are held stable until req_ready_i=1. They must not drop or change, even on flush.
  - On accept, go WAIT, or go DRAIN if the kill flag is set.
  - req_valid_o deasserts the cycle after the accept.
- State WAIT, on resp_valid_i (cycle M):
  - At M+1: line_o=resp_line_i, line_pc_o=pend_pc_o, line_valid_o=1, pend_valid_o=0; go IDLE.
  - A new miss may be detected in the IDLE cycle at M+1, so the back-to-back request is visible at M+2.
- State DRAIN:
  - Waits for the killed request's response and discards it (line buffer unchanged).
  - On resp_valid_i, go IDLE.
  - pend_valid_o=0 throughout.
- Flush (flush_i=1, any state):
  - Next cycle line_valid_o=0 and pend_valid_o=0. line_pc_o and line_o keep stale values.
  - IDLE: stays IDLE; a miss in the same cycle is ignored.
  - REQ: sets the kill flag; the request still completes its handshake and then goes to DRAIN.
  - WAIT: goes to DRAIN.
  - WAIT with resp_valid_i in the same cycle: flush wins, data discarded, go IDLE.
  - DRAIN: no effect.
- A miss while in REQ, WAIT or DRAIN is not queued. The fetch stage holds pc_valid_i until hit.
- The response bus is single-beat and in-order. resp_valid_i in IDLE or REQ is a protocol error; ignore it, with an assertion in simulation.

Optional Feature:
- Macro: ICACHE_LF_PERF_EN.
- With the macro defined, add the following outputs, all reset to 0:
  - miss_cnt_o (32 bits): +1 on each IDLE→REQ transition.
  - flush_kill_cnt_o (32 bits): +1 on each entry to DRAIN.
  - Both counters saturate at 0xFFFFFFFF.
- Without it, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Cold miss: reset, then pc_i=0x1004, pc_valid_i=1.
  - Next cycle: req_valid_o=1, req_addr_o=0x1000, pend_pc_o=0x1000.
  - req_ready_i at cycle 3, resp_valid_i at cycle 6 with 0xDEAD...BEEF.
  - Cycle 7: line_valid_o=1, line_pc_o=0x1000, line_o=0xDEAD...BEEF, pend_valid_o=0.
- Hit/pending: line holds 0x1000, pc_i=0x100C → no request. pc_i=0x2000 → request 0x2000; while pending, pc_i=0x2008 → no second request.
- Backpressure: req_ready_i=0 for 5 cycles → req_valid_o=1 and req_addr_o=0x3000 stable for all 5 cycles; single accept.
- Flush in WAIT: request 0x4000 accepted, flush_i pulse, response arrives 3 cycles later → line_valid_o=0, buffer unchanged, state IDLE, next miss 0x5000 issued normally.
- Flush in REQ and same-cycle flush+response: both cases discard data; flush+response leaves line_valid_o=0 at the next cycle.
- Async reset mid-WAIT: rst_n_i low between clock edges → all outputs 0 immediately; a late resp_valid_i after release is ignored. With ICACHE_LF_PERF_EN, miss_cnt_o=0 after reset.
